// File: rtl/add_seq_pkg.sv
// Shared constants and types for the word-serial multiword adder.
package add_seq_pkg;

  localparam int unsigned WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Word-index width; never narrower than one bit so WORDS=1 still has a counter.
  function automatic int unsigned idx_w(input int unsigned words);
    return (words <= 2) ? 1 : $clog2(words);
  endfunction

endpackage

// File: rtl/carry_select_adder_16bit.sv
// 16-bit carry-select adder: four 4-bit blocks, each precomputing both carry-in
// outcomes, with the real carry choosing between them.
module carry_select_adder_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [4:0] blk_s0 [4];
  logic [4:0] blk_s1 [4];

  for (genvar g = 0; g < 4; g++) begin : g_blk
    assign blk_s0[g] = {1'b0, a[g*4 +: 4]} + {1'b0, b[g*4 +: 4]};
    assign blk_s1[g] = {1'b0, a[g*4 +: 4]} + {1'b0, b[g*4 +: 4]} + 5'd1;
  end

  always_comb begin
    logic c;
    c   = cin;
    sum = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      sum[i*4 +: 4] = c ? blk_s1[i][3:0] : blk_s0[i][3:0];
      c             = c ? blk_s1[i][4]   : blk_s0[i][4];
    end
    cout = c;
  end

endmodule

// File: rtl/multiword_add_sequencer.sv
// Word-serial WORDS x 16-bit adder sharing one carry_select_adder_16bit, LS word first.
// Optional ADD_OVF_FLAG_EN adds a registered signed-overflow output (ovf).
module multiword_add_sequencer
  import add_seq_pkg::*;
#(
  parameter int unsigned WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_W*WORDS-1:0] a,
  input  logic [WORD_W*WORDS-1:0] b,
  input  logic                  cin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_W*WORDS-1:0] sum,
  output logic                  cout
`ifdef ADD_OVF_FLAG_EN
  ,
  output logic                  ovf
`endif
);

  localparam int unsigned W     = WORD_W * WORDS;
  localparam int unsigned IDX_W = idx_w(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  state_t           state, state_next;
  logic [W-1:0]     a_sr, b_sr;
  logic             carry;
  logic [IDX_W-1:0] idx;
  logic [WORD_W-1:0] add_sum;
  logic             add_cout;
  logic             last;

`ifdef ADD_OVF_FLAG_EN
  // Operand MSBs are shifted out of the operand registers, so keep them aside.
  logic a_msb, b_msb;
`endif

  carry_select_adder_16bit u_adder (
    .a   (a_sr[WORD_W-1:0]),
    .b   (b_sr[WORD_W-1:0]),
    .cin (carry),
    .sum (add_sum),
    .cout(add_cout)
  );

  assign last = (idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (in_valid)  state_next = RUN;
      RUN:     if (last)      state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr  <= '0;
      b_sr  <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef ADD_OVF_FLAG_EN
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            idx   <= '0;
`ifdef ADD_OVF_FLAG_EN
            a_msb <= a[W-1];
            b_msb <= b[W-1];
`endif
          end
        end
        RUN: begin
          sum[idx*WORD_W +: WORD_W] <= add_sum;
          carry <= add_cout;
          idx   <= idx + IDX_W'(1);
          a_sr  <= a_sr >> WORD_W;
          b_sr  <= b_sr >> WORD_W;
          if (last) begin
            cout <= add_cout;
`ifdef ADD_OVF_FLAG_EN
            ovf  <= (a_msb == b_msb) && (add_sum[WORD_W-1] != a_msb);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Scoreboard bench for multiword_add_sequencer (WORDS=4); ovf checks with ADD_OVF_FLAG_EN.
module tb_multiword_add_sequencer;

  localparam int unsigned WORDS = 4;
  localparam int unsigned W     = 16 * WORDS;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
`ifdef ADD_OVF_FLAG_EN
  logic         ovf;
  logic         ovf_q[$];
`endif

  logic [W:0]   sb_q[$];
  int unsigned  n_cmp = 0;
  int unsigned  n_bad = 0;
  int unsigned  cyc = 0;

  multiword_add_sequencer #(.WORDS(WORDS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout)
`ifdef ADD_OVF_FLAG_EN
    ,
    .ovf      (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push_exp(input logic [W-1:0] ea, input logic [W-1:0] eb, input logic ec);
    logic [W:0] e;
    e = {1'b0, ea} + {1'b0, eb} + (W+1)'(ec);
    sb_q.push_back(e);
`ifdef ADD_OVF_FLAG_EN
    ovf_q.push_back((ea[W-1] == eb[W-1]) && (e[W-1] != ea[W-1]));
`endif
  endtask

  // Holds in_valid until an accept edge (bounded) and records the expected result.
  task automatic accept_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic oc);
    logic rdy;
    a = oa; b = ob; cin = oc; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rdy = in_ready;
      step();
      if (rdy) break;
    end
    push_exp(oa, ob, oc);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int unsigned n);
    n = 0;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_cmp++; if (sum !== '0) begin n_bad++; $display("FAIL reset_sum got=%h exp=0", sum); end
    n_cmp++; if (cout !== 1'b0) begin n_bad++; $display("FAIL reset_cout got=%b exp=0", cout); end
`ifdef ADD_OVF_FLAG_EN
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
`endif
  endtask

  // Single op with latency check, scoreboard compare and output handshake.
  task automatic test_single(input string name, input logic [W-1:0] oa, input logic [W-1:0] ob,
                             input logic oc);
    int unsigned n;
    logic [W:0] e;
    accept_op(oa, ob, oc);
    wait_out(n);
    n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL %s_latency got=%0d exp=4", name, n); end
    if (out_valid) begin
      e = sb_q.pop_front();
      n_cmp++; if (sum !== e[W-1:0]) begin n_bad++; $display("FAIL %s_sum got=%h exp=%h", name, sum, e[W-1:0]); end
      n_cmp++; if (cout !== e[W]) begin n_bad++; $display("FAIL %s_cout got=%b exp=%b", name, cout, e[W]); end
`ifdef ADD_OVF_FLAG_EN
      begin
        logic eo;
        eo = ovf_q.pop_front();
        n_cmp++; if (ovf !== eo) begin n_bad++; $display("FAIL %s_ovf got=%b exp=%b", name, ovf, eo); end
      end
`endif
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL %s_back_idle got=%b exp=1", name, in_ready); end
  endtask

  task automatic test_backpressure();
    int unsigned n;
    logic [W:0] e;
    accept_op(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1);
    wait_out(n);
    e = sb_q.pop_front();
`ifdef ADD_OVF_FLAG_EN
    void'(ovf_q.pop_front());
`endif
    out_ready = 1'b0;
    a = 64'h1111_2222_3333_4444; b = 64'h0000_0000_0000_0005; cin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_out_valid[%0d] got=%b exp=1", i, out_valid); end
      n_cmp++; if (sum !== e[W-1:0]) begin n_bad++; $display("FAIL bp_sum[%0d] got=%h exp=%h", i, sum, e[W-1:0]); end
      n_cmp++; if (cout !== e[W]) begin n_bad++; $display("FAIL bp_cout[%0d] got=%b exp=%b", i, cout, e[W]); end
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", i, in_ready); end
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_idle_in_ready got=%b exp=1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_idle_out_valid got=%b exp=0", out_valid); end
    step();
    push_exp(a, b, cin);
    in_valid = 1'b0;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_new_accept got=%b exp=0", in_ready); end
    wait_out(n);
    n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL bp_new_latency got=%0d exp=4", n); end
    e = sb_q.pop_front();
`ifdef ADD_OVF_FLAG_EN
    void'(ovf_q.pop_front());
`endif
    n_cmp++; if (sum !== e[W-1:0]) begin n_bad++; $display("FAIL bp_new_sum got=%h exp=%h", sum, e[W-1:0]); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    accept_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1234_5678_9ABC_DEF0, 1'b0);
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    sb_q.delete();
`ifdef ADD_OVF_FLAG_EN
    ovf_q.delete();
`endif
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL abort_in_ready got=%b exp=1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL abort_out_valid got=%b exp=0", out_valid); end
    n_cmp++; if (sum !== '0) begin n_bad++; $display("FAIL abort_sum got=%h exp=0", sum); end
    n_cmp++; if (cout !== 1'b0) begin n_bad++; $display("FAIL abort_cout got=%b exp=0", cout); end
    test_single("after_abort", 64'd5, 64'd7, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] ops_a[2];
    logic [W-1:0] ops_b[2];
    int unsigned acc_cyc[2];
    int unsigned nacc, nout;
    logic acc, hs;
    logic [W:0] e;
    ops_a[0] = 64'd1;            ops_b[0] = 64'd2;
    ops_a[1] = 64'h1_0000_0000;  ops_b[1] = 64'hFFFF_FFFF;
    nacc = 0; nout = 0; acc_cyc[0] = 0; acc_cyc[1] = 0;
    a = ops_a[0]; b = ops_b[0]; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 40 && nout < 2; k++) begin
      acc = in_valid && in_ready;
      hs  = out_valid && out_ready;
      if (hs) begin
        if (sb_q.size() == 0) begin
          n_cmp++; n_bad++; $display("FAIL b2b_unexpected_output got=%h exp=none", sum);
        end else begin
          e = sb_q.pop_front();
`ifdef ADD_OVF_FLAG_EN
          void'(ovf_q.pop_front());
`endif
          n_cmp++; if (sum !== e[W-1:0]) begin n_bad++; $display("FAIL b2b_sum[%0d] got=%h exp=%h", nout, sum, e[W-1:0]); end
          n_cmp++; if (cout !== e[W]) begin n_bad++; $display("FAIL b2b_cout[%0d] got=%b exp=%b", nout, cout, e[W]); end
        end
        nout++;
      end
      step();
      if (acc && nacc < 2) begin
        acc_cyc[nacc] = cyc;
        push_exp(a, b, cin);
        nacc++;
        if (nacc == 1) begin a = ops_a[1]; b = ops_b[1]; end
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    n_cmp++; if (nout !== 2) begin n_bad++; $display("FAIL b2b_outputs got=%0d exp=2", nout); end
    n_cmp++; if (acc_cyc[1] - acc_cyc[0] !== 6) begin
      n_bad++; $display("FAIL b2b_accept_spacing got=%0d exp=6", acc_cyc[1] - acc_cyc[0]);
    end
  endtask

  initial begin
    test_reset();
    test_single("word_carry", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0);
    test_single("full_carry", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
    test_single("mixed", 64'h8000_FFFF_0001_7FFF, 64'h8000_0001_FFFF_8001, 1'b1);
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
`ifdef ADD_OVF_FLAG_EN
    test_single("ovf_pos", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    test_single("ovf_neg", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
